// File: rtl/fft_ram_pkg.sv
// fft_ram_pkg: shared constants, state encoding and address bit reversal for the FFT frame loader
package fft_ram_pkg;
    localparam int FFT_DW = 23;
    localparam int FFT_AW = 8;
    localparam int FFT_N = 1 << FFT_AW;
    typedef enum logic {ST_FILL, ST_DRAIN} state_e;
    function automatic logic [FFT_AW-1:0] bitrev(input logic [FFT_AW-1:0] a);
        logic [FFT_AW-1:0] r;
        for (int i = 0; i < FFT_AW; i++) r[i] = a[FFT_AW-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample stream in, FFT stream out and the single-port RAM port
interface fft_frame_loader_if;
    import fft_ram_pkg::*;
    logic              s_valid;
    logic              s_ready;
    logic [FFT_DW-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [FFT_DW-1:0] m_data;
    logic              ram_wea;
    logic [FFT_AW-1:0] ram_addra;
    logic [FFT_DW-1:0] ram_dina;
    logic [FFT_DW-1:0] ram_douta;
    logic              busy;
    modport slave (
        input  s_valid, s_data, m_ready, ram_douta,
        output s_ready, m_valid, m_data, m_last, ram_wea, ram_addra, ram_dina, busy
    );
    modport master (
        output s_valid, s_data, m_ready, ram_douta,
        input  s_ready, m_valid, m_data, m_last, ram_wea, ram_addra, ram_dina, busy
    );
endinterface

// File: rtl/fft_skid_buf.sv
// fft_skid_buf: 2-entry data+last FIFO whose head drives the output stream
module fft_skid_buf #(
    parameter int DW = 23
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    output logic          valid_o,
    output logic [1:0]    count_o
);
    logic [DW:0] e0_q, e0_d, e1_q, e1_d;
    logic        rp_q, rp_d, wp_q, wp_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [DW:0] head;
    always_ff @(posedge clka) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            rp_q  <= 1'b0;
            wp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        e0_d  = (push_i && !wp_q) ? {last_i, data_i} : e0_q;
        e1_d  = (push_i && wp_q) ? {last_i, data_i} : e1_q;
        wp_d  = wp_q ^ push_i;
        rp_d  = rp_q ^ pop_i;
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
        head  = rp_q ? e1_q : e0_q;
    end
    assign valid_o = cnt_q != 2'd0;
    assign data_o  = head[DW-1:0];
    assign last_o  = valid_o && head[DW];
    assign count_o = cnt_q;
endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: writes one 256-sample frame into the single-port FFT RAM,
// then streams it back out (bit-reversed or natural order) before accepting the next frame
module fft_frame_loader
    import fft_ram_pkg::*;
#(
    parameter bit BITREV = 1'b1
) (
    input logic               clka,
    input logic               rst,
    fft_frame_loader_if.slave bus
);
    state_e            state_q, state_d;
    logic [FFT_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [FFT_AW:0]   rd_cnt_q, rd_cnt_d;
    logic              infl_q, infl_d, infl_last_q, infl_last_d;
    logic              wr, pop, issue, done;
    logic [1:0]        buf_cnt;
    logic [FFT_AW-1:0] rd_addr;
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end
    // Reads are throttled so the word in flight always has a buffer slot once this cycle's pop is counted.
    always_comb begin
        wr          = state_q == ST_FILL && bus.s_valid;
        pop         = bus.m_valid && bus.m_ready;
        done        = pop && bus.m_last;
        issue       = state_q == ST_DRAIN && !rd_cnt_q[FFT_AW] &&
                      (buf_cnt + 2'(infl_q) - 2'(pop)) < 2'd2;
        wr_cnt_d    = wr_cnt_q + FFT_AW'(wr);
        rd_cnt_d    = done ? '0 : rd_cnt_q + (FFT_AW+1)'(issue);
        infl_d      = issue;
        infl_last_d = issue && rd_cnt_q[FFT_AW-1:0] == '1;
        state_d     = (wr && wr_cnt_q == '1) ? ST_DRAIN : (done ? ST_FILL : state_q);
        rd_addr     = rd_cnt_q[FFT_AW-1:0];
    end
    assign bus.s_ready   = state_q == ST_FILL;
    assign bus.busy      = state_q == ST_DRAIN;
    assign bus.ram_wea   = wr;
    assign bus.ram_dina  = wr ? bus.s_data : '0;
    assign bus.ram_addra = state_q == ST_FILL ? wr_cnt_q : (BITREV ? bitrev(rd_addr) : rd_addr);
    fft_skid_buf #(.DW(FFT_DW)) u_buf (
        .clka    (clka),
        .rst     (rst),
        .push_i  (infl_q),
        .data_i  (bus.ram_douta),
        .last_i  (infl_last_q),
        .pop_i   (pop),
        .data_o  (bus.m_data),
        .last_o  (bus.m_last),
        .valid_o (bus.m_valid),
        .count_o (buf_cnt)
    );
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: two loaders (bit-reversed and natural order) in lockstep against a frame-level model
module tb_fft_frame_loader;
    import fft_ram_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic              sv = 1'b0;
    logic [FFT_DW-1:0] sd = '0;
    logic              mr = 1'b0;
    fft_frame_loader_if b1();
    fft_frame_loader_if b0();
    assign b1.s_valid = sv;
    assign b1.s_data  = sd;
    assign b1.m_ready = mr;
    assign b0.s_valid = sv;
    assign b0.s_data  = sd;
    assign b0.m_ready = mr;
    fft_frame_loader #(.BITREV(1'b1)) u1 (.clka(clk), .rst(rst), .bus(b1));
    fft_frame_loader #(.BITREV(1'b0)) u0 (.clka(clk), .rst(rst), .bus(b0));
    logic [FFT_DW-1:0] ram1 [FFT_N];
    logic [FFT_DW-1:0] ram0 [FFT_N];
    logic [FFT_DW-1:0] q1 = '0, q0 = '0;
    always @(posedge clk) begin
        if (b1.ram_wea) ram1[b1.ram_addra] <= b1.ram_dina;
        if (b0.ram_wea) ram0[b0.ram_addra] <= b0.ram_dina;
        q1 <= ram1[b1.ram_addra];
        q0 <= ram0[b0.ram_addra];
    end
    assign b1.ram_douta = q1;
    assign b0.ram_douta = q0;
    int n_cmp = 0, n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask
    function automatic int rev(input int x);
        int r = 0;
        for (int i = 0; i < 8; i++) if ((x >> i) & 1) r += 1 << (7 - i);
        return r;
    endfunction
    bit                m_fill = 1'b1;
    int                k = 0, oi = 0, done = 0, phase = 0, busy_cycles = 0;
    logic [FFT_DW-1:0] frame [FFT_N];
    logic [FFT_DW-1:0] log_d [2][FFT_N];
    logic              log_l [2][FFT_N];
    logic              stall_p [2];
    logic [FFT_DW-1:0] data_p [2];
    logic              last_p [2];
    logic              mv [2], ml [2], sr [2], we [2], bz [2];
    logic [FFT_DW-1:0] md [2], di [2];
    logic [FFT_AW-1:0] ad [2];
    initial begin
        stall_p[0] = 1'b0;
        stall_p[1] = 1'b0;
    end
    always @(negedge clk) begin
        mv[1] = b1.m_valid; md[1] = b1.m_data; ml[1] = b1.m_last; sr[1] = b1.s_ready;
        we[1] = b1.ram_wea; bz[1] = b1.busy;  ad[1] = b1.ram_addra; di[1] = b1.ram_dina;
        mv[0] = b0.m_valid; md[0] = b0.m_data; ml[0] = b0.m_last; sr[0] = b0.s_ready;
        we[0] = b0.ram_wea; bz[0] = b0.busy;  ad[0] = b0.ram_addra; di[0] = b0.ram_dina;
        if (rst) begin
            m_fill = 1'b1; k = 0; oi = 0;
            stall_p[0] = 1'b0; stall_p[1] = 1'b0;
        end else begin
            automatic bit was_fill = m_fill;
            for (int d = 0; d < 2; d++) begin
                chk("s_ready", sr[d], was_fill);
                chk("ram_wea", we[d], was_fill && sv);
                chk("busy", bz[d], !was_fill);
                if (was_fill) chk("m_valid_in_fill", mv[d], 1'b0);
                if (stall_p[d]) begin
                    chk("stall_valid", mv[d], 1'b1);
                    chk("stall_data", md[d], data_p[d]);
                    chk("stall_last", ml[d], last_p[d]);
                end
                if (we[d]) begin
                    chk("wr_addr", ad[d], k);
                    chk("wr_data", di[d], sd);
                end
            end
            chk("lockstep_valid", mv[0], mv[1]);
            if (phase == 1 && bz[1]) busy_cycles++;
            if (was_fill && sv) begin
                frame[k] = sd;
                k++;
                if (k == FFT_N) m_fill = 1'b0;
            end
            if (!was_fill && mv[1] && mr) begin
                for (int d = 0; d < 2; d++) begin
                    chk("m_data", md[d], frame[d == 1 ? rev(oi) : oi]);
                    chk("m_last", ml[d], oi == FFT_N - 1);
                    log_d[d][oi] = md[d];
                    log_l[d][oi] = ml[d];
                end
                oi++;
                if (oi == FFT_N) begin
                    m_fill = 1'b1; oi = 0; k = 0; done++;
                end
            end
            for (int d = 0; d < 2; d++) begin
                stall_p[d] = mv[d] && !mr;
                data_p[d]  = md[d];
                last_p[d]  = ml[d];
            end
        end
    end
    task automatic drive_until(input int target, input int psv, input int pmr);
        int c = 0;
        while (done < target && c < 8000) begin
            sv = $urandom_range(0, 99) < psv;
            sd = FFT_DW'($urandom);
            mr = $urandom_range(0, 99) < pmr;
            @(posedge clk);
            #1;
            c++;
        end
        sv = 1'b0;
        n_cmp++;
        if (done < target) begin
            n_err++;
            $display("FAIL timeout: frames done %0d expected %0d", done, target);
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", b1.s_ready, 1'b1);
        chk("rst_m_valid", b1.m_valid, 1'b0);
        chk("rst_m_last", b1.m_last, 1'b0);
        chk("rst_m_data", b1.m_data, 0);
        chk("rst_ram_wea", b1.ram_wea, 1'b0);
        chk("rst_ram_addra", b1.ram_addra, 0);
        chk("rst_ram_dina", b1.ram_dina, 0);
        chk("rst_busy", b1.busy, 1'b0);
        chk("rst_m_valid_nat", b0.m_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        phase = 1;
        for (int i = 0; i < FFT_N; i++) begin
            sv = 1'b1;
            sd = FFT_DW'(2 * i);
            mr = 1'b1;
            @(posedge clk);
            #1;
        end
        sv = 1'b0;
        drive_until(1, 0, 100);
        phase = 0;
        chk("busy_cycles", busy_cycles, FFT_N + 2);
        chk("rev_out0", log_d[1][0], 0);
        chk("rev_out1", log_d[1][1], 256);
        chk("rev_out2", log_d[1][2], 128);
        chk("rev_out3", log_d[1][3], 384);
        chk("rev_last_val", log_d[1][255], 510);
        chk("rev_last_flag", log_l[1][255], 1'b1);
        chk("rev_not_last", log_l[1][254], 1'b0);
        chk("nat_out1", log_d[0][1], 2);
        chk("nat_out3", log_d[0][3], 6);
        chk("nat_last_val", log_d[0][255], 510);
        drive_until(2, 50, 50);
        repeat (100) begin
            sv = 1'b1;
            sd = FFT_DW'($urandom);
            mr = $urandom_range(0, 1);
            @(posedge clk);
            #1;
        end
        sv = 1'b0;
        chk("partial_count", k, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("partial_discarded", k, 0);
        drive_until(3, 80, 60);
        drive_until(5, 100, 100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
